vga_sink_monitor: RTL and testbench

Synthesizable VGA sink that sits on the far end of a design's TinyVGA-style `uo_out` bus and turns the emitted sync and colour pins back into pixel coordinates and colour. It locks to the incoming hsync/vsync, checks line and frame timing against parameters, and produces a per-frame checksum. The bench uses it as a self-checking receiver for art generators such as the nn2 design.

---
 rtl/vga_sink_monitor.sv | 161 ++++++++++++++++
 tb/tb_vga_sink_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sink_monitor.sv
// VGA sink: recovers pixel coordinates and colour from a TinyVGA-style uo_out bus,
// locks to sync timing, flags line/frame length errors and checksums each frame.
module vga_sink_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int H_TOTAL         = 800,
  parameter int V_ACTIVE        = 480,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int V_TOTAL         = 525,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_in,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [5:0]  rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [7:0]  frame_count,
  output logic        h_err,
  output logic        v_err
);

  localparam logic       SAL     = (SYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] S1_IDLE = SAL ? 8'h88 : 8'h00;
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_END   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state_q, state_d;

  logic [7:0]  s1_q;
  logic        hs, vs, hs_prev_q, vs_prev_q, hs_edge, vs_edge;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic        h_bad, v_bad, h_err_set, v_err_set;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic [5:0]  rgb_s1;
  logic        active;
  logic [15:0] acc_q, acc_d;
  logic        pv_q, pv_d, last_q, last_d, fd_q, fd_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  rgb_q, rgb_d;
  logic [15:0] fsum_q, fsum_d;
  logic [7:0]  fcount_q, fcount_d;

  // hc_d/vc_d are the counts aligned with the pixel currently held in stage 1;
  // hc_q/vc_q therefore hold the previous line/frame's final count at an edge.
  always_comb begin
    hs      = s1_q[7] ^ SAL;
    vs      = s1_q[3] ^ SAL;
    hs_edge = hs & ~hs_prev_q;
    vs_edge = vs & ~vs_prev_q;
    hc_d    = hs_edge ? '0 : ((hc_q == '1) ? hc_q : hc_q + 10'd1);
    vc_d    = vc_q;
    if (vs_edge)                   vc_d = '0;
    else if (hs_edge && vc_q != '1) vc_d = vc_q + 10'd1;
    h_bad   = hs_edge && (hc_q != H_END);
    v_bad   = vs_edge && (vc_q != V_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (vs_edge) state_d = CHECK;
      CHECK:   if (h_bad) state_d = HUNT;
               else if (vs_edge) state_d = v_bad ? CHECK : LOCKED;
      LOCKED:  if (h_bad) state_d = HUNT;
               else if (v_bad) state_d = CHECK;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    h_err_set = locked && h_bad;
    v_err_set = locked && !h_bad && v_bad;
  end

  always_comb begin
    rgb_s1   = {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]};
    active   = locked && (hc_d >= H_START) && (hc_d <= H_LAST) &&
               (vc_d >= V_START) && (vc_d <= V_LAST);
    pv_d     = active;
    x_d      = active ? hc_d - H_START : '0;
    y_d      = active ? vc_d - V_START : '0;
    rgb_d    = active ? rgb_s1 : '0;
    acc_d    = acc_q;
    if (vs_edge)     acc_d = '1;
    else if (active) acc_d = {acc_q[14:0], acc_q[15]} ^ {10'b0, rgb_s1};
    last_d   = active && (hc_d == H_LAST) && (vc_d == V_LAST);
    // acc_q already includes the last pixel when last_q is high
    fd_d     = last_q;
    fsum_d   = last_q ? acc_q : fsum_q;
    fcount_d = last_q ? fcount_q + 8'd1 : fcount_q;
    h_err_d  = h_err_q | h_err_set;
    v_err_d  = v_err_q | v_err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= S1_IDLE;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      acc_q     <= '1;
      pv_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      last_q    <= 1'b0;
      fd_q      <= 1'b0;
      fsum_q    <= '0;
      fcount_q  <= '0;
      h_err_q   <= 1'b0;
      v_err_q   <= 1'b0;
    end else begin
      s1_q      <= vga_in;
      hs_prev_q <= hs;
      vs_prev_q <= vs;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      acc_q     <= acc_d;
      pv_q      <= pv_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      last_q    <= last_d;
      fd_q      <= fd_d;
      fsum_q    <= fsum_d;
      fcount_q  <= fcount_d;
      h_err_q   <= h_err_d;
      v_err_q   <= v_err_d;
    end
  end

  assign pixel_valid = pv_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rgb         = rgb_q;
  assign frame_done  = fd_q;
  assign frame_sum   = fsum_q;
  assign frame_count = fcount_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Scoreboard bench for vga_sink_monitor: a reduced-size timing source drives an
// active-low-sync instance and an active-high-sync instance with the same frames.
module tb_vga_sink_monitor;
  localparam int HA = 8, HS = 2, HB = 2, HT = 16;
  localparam int VA = 4, VS = 1, VB = 1, VT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vin_n = 8'h88, vin_p = 8'h00;
  logic        pv [2];
  logic [9:0]  xo [2];
  logic [9:0]  yo [2];
  logic [5:0]  rgbo [2];
  logic        lk [2];
  logic        fd [2];
  logic [15:0] fs [2];
  logic [7:0]  fc [2];
  logic        he [2];
  logic        ve [2];

  always #5 clk = ~clk;

  vga_sink_monitor #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
                     .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
                     .SYNC_ACTIVE_LOW(1)) u_dut_n (
    .clk(clk), .rst(rst), .vga_in(vin_n), .pixel_valid(pv[0]), .x(xo[0]), .y(yo[0]),
    .rgb(rgbo[0]), .locked(lk[0]), .frame_done(fd[0]), .frame_sum(fs[0]),
    .frame_count(fc[0]), .h_err(he[0]), .v_err(ve[0]));

  vga_sink_monitor #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
                     .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
                     .SYNC_ACTIVE_LOW(0)) u_dut_p (
    .clk(clk), .rst(rst), .vga_in(vin_p), .pixel_valid(pv[1]), .x(xo[1]), .y(yo[1]),
    .rgb(rgbo[1]), .locked(lk[1]), .frame_done(fd[1]), .frame_sum(fs[1]),
    .frame_count(fc[1]), .h_err(he[1]), .v_err(ve[1]));

  typedef struct { int x; int y; int rgb; int cyc; } pix_t;
  typedef struct { logic [15:0] sum; logic [7:0] cnt; int cyc; } fr_t;
  pix_t pq[$];
  fr_t  fq[$];
  int   rd_pix [2] = '{0, 0};
  int   rd_fr  [2] = '{0, 0};
  int   pv_cnt [2] = '{0, 0};
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  logic       exp_locked = 1'b0, exp_herr = 1'b0, exp_verr = 1'b0;
  logic [7:0] exp_count = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: unexpected output event at cycle %0d", name, cyc);
  endtask

  function automatic logic [54:0] all_out(input int d);
    return {pv[d], xo[d], yo[d], rgbo[d], lk[d], fd[d], fs[d], fc[d], he[d], ve[d]};
  endfunction

  task automatic check_out(input int d);
    pix_t p;
    fr_t  f;
    if (pv[d]) begin
      pv_cnt[d]++;
      if (rd_pix[d] < pq.size()) begin
        p = pq[rd_pix[d]];
        rd_pix[d]++;
        chk($sformatf("pix_xyrgb_d%0d", d), {xo[d], yo[d], rgbo[d]},
            {10'(p.x), 10'(p.y), 6'(p.rgb)});
        chk($sformatf("pix_cycle_d%0d", d), 64'(cyc), 64'(p.cyc));
      end else fail_now($sformatf("pix_extra_d%0d", d));
    end else begin
      chk($sformatf("idle_zero_d%0d", d), {xo[d], yo[d], rgbo[d]}, 64'd0);
      if (!lk[d]) pv_cnt[d] = 0;
    end
    if (fd[d]) begin
      if (rd_fr[d] < fq.size()) begin
        f = fq[rd_fr[d]];
        rd_fr[d]++;
        chk($sformatf("frame_sum_d%0d", d), fs[d], f.sum);
        chk($sformatf("frame_count_d%0d", d), fc[d], f.cnt);
        chk($sformatf("frame_cycle_d%0d", d), 64'(cyc), 64'(f.cyc));
        chk($sformatf("frame_pixels_d%0d", d), 64'(pv_cnt[d]), 64'(HA * VA));
      end else fail_now($sformatf("frame_extra_d%0d", d));
      pv_cnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) check_out(d);
  end

  // c is {R1,R0,G1,G0,B1,B0}; syncs are given as asserted flags
  task automatic drive(input logic [5:0] c, input logic hs_a, input logic vs_a);
    vin_n = {~hs_a, c[0], c[2], c[4], ~vs_a, c[1], c[3], c[5]};
    vin_p = vin_n ^ 8'h88;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(6'h00, 1'b0, 1'b0);
    end
  endtask

  // pat: 0 = x[5:0], 1 = black, 2 = {y[2:0],x[2:0]}; bad_line is shortened by one cycle
  task automatic drive_frame(input int pat, input logic lk_exp, input int bad_line,
                             input int nlines);
    logic [15:0] acc;
    logic [5:0]  c;
    int          len, xx, yy;
    logic        act;
    acc = 16'hFFFF;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(posedge clk); #1;
        act = (h >= HS + HB) && (h < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        xx  = h - (HS + HB);
        yy  = l - (VS + VB);
        if (!act)          c = 6'h2D;
        else if (pat == 0) c = 6'(xx);
        else if (pat == 1) c = 6'h00;
        else               c = 6'(((yy & 7) << 3) | (xx & 7));
        drive(c, h < HS, l < VS);
        if (l == 0 && h == 1)
          for (int d = 0; d < 2; d++) chk($sformatf("lock_before_d%0d", d), lk[d], exp_locked);
        if (l == 0 && h == 2) begin
          for (int d = 0; d < 2; d++) chk($sformatf("lock_after_d%0d", d), lk[d], lk_exp);
          exp_locked = lk_exp;
        end
        if (bad_line >= 0 && l == bad_line + 1 && h == 0) begin
          exp_locked = 1'b0;
          exp_herr   = 1'b1;
        end
        if (bad_line >= 0 && l == bad_line + 1 && h == 2)
          for (int d = 0; d < 2; d++) begin
            chk($sformatf("lock_drop_d%0d", d), lk[d], 1'b0);
            chk($sformatf("h_err_set_d%0d", d), he[d], 1'b1);
          end
        if (act && exp_locked) begin
          acc = {acc[14:0], acc[15]} ^ {10'b0, c};
          pq.push_back('{xx, yy, int'(c), cyc + 2});
          if (xx == HA - 1 && yy == VA - 1) begin
            exp_count++;
            fq.push_back('{acc, exp_count, cyc + 3});
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("h_err_d%0d", d), he[d], exp_herr);
      chk($sformatf("v_err_d%0d", d), ve[d], exp_verr);
      chk($sformatf("lock_end_d%0d", d), lk[d], exp_locked);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vin_n = 8'($urandom);
      vin_p = 8'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("reset_outputs_d%0d", d), all_out(d), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(6'h00, 1'b0, 1'b0);
    idle(4);

    drive_frame(0, 1'b0, -1, VT);      // HUNT -> CHECK
    drive_frame(0, 1'b1, -1, VT);      // locked, frame_count 1
    drive_frame(2, 1'b1, -1, VT);      // frame_count 2
    drive_frame(0, 1'b1, 3, VT);       // short line: h_err, no frame_done
    drive_frame(0, 1'b0, -1, VT);      // HUNT -> CHECK
    drive_frame(2, 1'b1, -1, VT);      // relocked, h_err stays set
    drive_frame(0, 1'b1, -1, VT - 1);  // short frame still completes its active area
    exp_verr = 1'b1;
    drive_frame(0, 1'b0, -1, VT);      // v_err, LOCKED -> CHECK
    drive_frame(0, 1'b1, -1, VT);      // relocked
    for (int i = 0; i < 256; i++) drive_frame(1, 1'b1, -1, VT);
    chk("count_wrapped", 64'(exp_count), 64'(8'd5 + 8'd0));

    idle(3);
    for (int d = 0; d < 2; d++) chk($sformatf("lock_idle_d%0d", d), lk[d], 1'b1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_mid_lock_d%0d", d), all_out(d), 64'd0);
      chk($sformatf("pix_pending_d%0d", d), 64'(rd_pix[d]), 64'(pq.size()));
      chk($sformatf("frame_pending_d%0d", d), 64'(rd_fr[d]), 64'(fq.size()));
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
